click_demux_sync: RTL
=====================

Name: click_demux_sync

Overview:
- Clocked 2-phase bundled-data demultiplexer; the split counterpart to the click merge.
- Accepts one token on input channel A and routes it to output channel B or output channel C, selected by a sel bit bundled with the data.
- Bridges asynchronous click-style producers and consumers into a single clock domain. Every incoming req/ack is synchronised before use.

Parameters:
- DATA_WIDTH, 8, width of the data bundle on all channels.
- PHASE_INIT_A, 0, reset value of inA_ack and of the inA_req synchroniser.
- PHASE_INIT_B, 0, reset value of outB_req and of the outB_ack synchroniser.
- PHASE_INIT_C, 0, reset value of outC_req and of the outC_ack synchroniser.
- SYNC_STAGES, 2, flop stages per synchroniser; legal values are 2 or more.

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous, active-low reset.
- inA_req  input  1  2-phase request from the producer; a token is present when the synchronised req differs from inA_ack.
- inA_ack  output  1  2-phase acknowledge to the producer.
- inA_sel  input  1  route select, bundled with the data: 0 selects B, 1 selects C.
- inA_data  input  DATA_WIDTH  payload.
- outB_req  output  1  2-phase request to consumer B.
- outB_ack  input  1  2-phase acknowledge from consumer B.
- outB_data  output  DATA_WIDTH  registered payload for B.
- outC_req  output  1  2-phase request to consumer C.
- outC_ack  input  1  2-phase acknowledge from consumer C.
- outC_data  output  DATA_WIDTH  registered payload for C.

Behaviour:
- Reset, asynchronous while rst is 0:
  - inA_ack = PHASE_INIT_A, outB_req = PHASE_INIT_B, outC_req = PHASE_INIT_C.
  - outB_data = 0, outC_data = 0.
  - FSM = IDLE.
  - Synchronisers preset to the matching phase values, so no spurious token appears at release.
- Synchronisers: inA_req, outB_ack and outC_ack each pass through SYNC_STAGES flops. Names below: sA, sB, sC.
- FSM states are IDLE, LAUNCH and WAIT.
- IDLE:
  - If sA != inA_ack: capture inA_sel into a sel register and inA_data into the selected output's data register, then go to LAUNCH.
  - The non-selected data register holds its value.
- LAUNCH: toggle the selected outX_req, then go to WAIT. Data was registered one edge earlier, so bundled-data setup is met.
- WAIT:
  - When the selected output's synchronised ack equals its req, toggle inA_ack and go to IDLE.
  - The non-selected ack is ignored.
- Forward latency:
  - inA_req toggle sampled at edge 0 → data captured at edge SYNC_STAGES → outX_req toggles at edge SYNC_STAGES+1.
  - With the default SYNC_STAGES this is edge 3.
- Return latency: outX_ack toggle sampled at edge 0 → inA_ack toggles at edge SYNC_STAGES.
- One token in flight at a time; throughput is at most one token per (2·SYNC_STAGES+2) cycles.
- Producer rules:
  - inA_data and inA_sel must be stable from the inA_req toggle until the matching inA_ack toggle.
  - An inA_req toggle before that ack is a protocol violation. The block ignores it until IDLE and then sees at most one token.
- Consumer rules:
  - An ack toggle on a channel with no outstanding token is ignored in IDLE and LAUNCH.
  - Such a toggle permanently desynchronises that channel; this is a protocol violation and is not recovered.
- Simultaneous events: outB_ack and outC_ack toggling in the same cycle. Only the selected channel's ack advances the FSM.
- Reset mid-operation, from any state:
  - Return to IDLE; all phases and data registers go to their reset values.
  - The in-flight token is dropped; the environment must reset too.
- Non-zero PHASE_INIT values: a differing PHASE_INIT_B or PHASE_INIT_C is legal and means no token is outstanding at reset. Tokens are detected only by difference, never by level.

Optional Feature:
- Macro name: CLICK_DEMUX_STATS_EN.
- When defined:
  - Adds output ports cntB and cntC, each 16 bits.
  - Each counts tokens completed on its channel, incrementing in the WAIT→IDLE transition.
  - Counters wrap from 0xFFFF to 0x0000 and reset to 0.
- When undefined: the ports and counters are absent. Routing behaviour and latency are identical either way.

Test Plan:
- Reset release with all PHASE_INIT = 0 and inputs quiet → inA_ack = 0, outB_req = 0, outC_req = 0, both data outputs 0. No req toggle for 20 cycles.
- Toggle inA_req 0→1 with sel = 0 and data = 0xA5, sampled at edge 0 → outB_data = 0xA5 from edge 2, outB_req toggles to 1 at edge 3, outC_req unchanged. Toggle outB_ack 0→1 → inA_ack goes to 1 two edges later.
- Two tokens back-to-back: sel = 1, data = 0x3C, then sel = 0, data = 0x96 → C receives 0x3C and B receives 0x96, each req toggling exactly once, in order. With CLICK_DEMUX_STATS_EN defined: cntB = 1, cntC = 1.
- Token routed to C, with outB_ack toggled spuriously in WAIT → FSM stays in WAIT and inA_ack unchanged, until outC_ack toggles.
- Assert rst in WAIT with outC_req = 1 → outC_req = PHASE_INIT_C and inA_ack = PHASE_INIT_A immediately, without waiting for a clock edge. After release with matching environment phases, a new token routes normally.
- PHASE_INIT_A = 1 with inA_req held at 1 → no token detected after reset. Toggle inA_req to 0 → exactly one token is delivered.

Source files
------------

// File: rtl/click_demux_sync.sv
// Clocked 2-phase bundled-data demultiplexer: routes one token from channel A to B or C by a bundled sel bit.
// Optional per-channel completion counters (cntB, cntC) are enabled with `define CLICK_DEMUX_STATS_EN.
module click_demux_sync #(
    parameter int DATA_WIDTH   = 8,
    parameter bit PHASE_INIT_A = 1'b0,
    parameter bit PHASE_INIT_B = 1'b0,
    parameter bit PHASE_INIT_C = 1'b0,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inA_req,
    output logic                  inA_ack,
    input  logic                  inA_sel,
    input  logic [DATA_WIDTH-1:0] inA_data,
    output logic                  outB_req,
    input  logic                  outB_ack,
    output logic [DATA_WIDTH-1:0] outB_data,
    output logic                  outC_req,
    input  logic                  outC_ack,
    output logic [DATA_WIDTH-1:0] outC_data
`ifdef CLICK_DEMUX_STATS_EN
    ,
    output logic [15:0]           cntB,
    output logic [15:0]           cntC
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_a_r;
    logic [SYNC_STAGES-1:0] sync_b_r;
    logic [SYNC_STAGES-1:0] sync_c_r;
    logic                   sa_s;
    logic                   sb_s;
    logic                   sc_s;
    logic                   ack_match_s;

    state_t                 state_r;
    logic                   sel_r;
    logic                   ack_a_r;
    logic                   req_b_r;
    logic                   req_c_r;
    logic [DATA_WIDTH-1:0]  data_b_r;
    logic [DATA_WIDTH-1:0]  data_c_r;
`ifdef CLICK_DEMUX_STATS_EN
    logic [15:0]            cnt_b_r;
    logic [15:0]            cnt_c_r;
`endif

    // Synchronisers preset to the idle phases so release never shows a phantom token.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a_r <= {SYNC_STAGES{PHASE_INIT_A}};
            sync_b_r <= {SYNC_STAGES{PHASE_INIT_B}};
            sync_c_r <= {SYNC_STAGES{PHASE_INIT_C}};
        end else begin
            sync_a_r <= {sync_a_r[SYNC_STAGES-2:0], inA_req};
            sync_b_r <= {sync_b_r[SYNC_STAGES-2:0], outB_ack};
            sync_c_r <= {sync_c_r[SYNC_STAGES-2:0], outC_ack};
        end
    end

    assign sa_s = sync_a_r[SYNC_STAGES-1];
    assign sb_s = sync_b_r[SYNC_STAGES-1];
    assign sc_s = sync_c_r[SYNC_STAGES-1];

    // Only the routed channel's ack can close the handshake.
    assign ack_match_s = sel_r ? (sc_s == req_c_r) : (sb_s == req_b_r);

    // Handshake FSM; every output is a register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            sel_r    <= 1'b0;
            ack_a_r  <= PHASE_INIT_A;
            req_b_r  <= PHASE_INIT_B;
            req_c_r  <= PHASE_INIT_C;
            data_b_r <= {DATA_WIDTH{1'b0}};
            data_c_r <= {DATA_WIDTH{1'b0}};
`ifdef CLICK_DEMUX_STATS_EN
            cnt_b_r  <= 16'd0;
            cnt_c_r  <= 16'd0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sa_s != ack_a_r) begin
                        sel_r <= inA_sel;
                        if (inA_sel) begin
                            data_c_r <= inA_data;
                        end else begin
                            data_b_r <= inA_data;
                        end
                        state_r <= ST_LAUNCH;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    // Data settled one edge ago, so the req toggle respects bundled-data setup.
                    if (sel_r) begin
                        req_c_r <= ~req_c_r;
                    end else begin
                        req_b_r <= ~req_b_r;
                    end
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ack_match_s) begin
                        ack_a_r <= ~ack_a_r;
`ifdef CLICK_DEMUX_STATS_EN
                        if (sel_r) begin
                            cnt_c_r <= cnt_c_r + 16'd1;
                        end else begin
                            cnt_b_r <= cnt_b_r + 16'd1;
                        end
`endif
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign inA_ack   = ack_a_r;
    assign outB_req  = req_b_r;
    assign outC_req  = req_c_r;
    assign outB_data = data_b_r;
    assign outC_data = data_c_r;
`ifdef CLICK_DEMUX_STATS_EN
    assign cntB      = cnt_b_r;
    assign cntC      = cnt_c_r;
`endif

endmodule
